fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Native, parametrised pipelined IEEE-754-style floating-point multiplier; vendor-IP-free successor to the
//  fixed binary32 multiplier wrapper. Accepts operand pairs on an AXI-Stream-style slave, returns the product
//  with exception flags on a master. Adds full valid/ready backpressure, generic exponent/mantissa width and
//  round-to-nearest-even. Sits in the datapath wherever FP products feed downstream accumulators.
// PARAMETERS
//  EXP_W   8    exponent field width (bias = 2^(EXP_W-1)-1)
//  MAN_W   23   stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W
// PORTS
//  aclk                  in   1   clock, all logic on rising edge
//  aresetn               in   1   asynchronous active-low reset
//  aclken                in   1   clock enable; low = whole block frozen, s_axis_tready forced 0
//  s_axis_tvalid         in   1   operand pair valid (a and b travel together)
//  s_axis_tready         out  1   block accepts pair this cycle
//  s_axis_a_tdata        in   W   operand A
//  s_axis_b_tdata        in   W   operand B
//  m_axis_result_tvalid  out  1   product valid
//  m_axis_result_tready  in   1   downstream accepts product
//  m_axis_result_tdata   out  W   product
//  m_axis_result_tuser   out  3   flags: [0] underflow, [1] overflow, [2] invalid_op
// BEHAVIOUR
//  Reset: all stage valids 0; m_axis_result_tvalid=0, tdata=0, tuser=0; s_axis_tready=0 while aresetn low.
//  Reset mid-operation discards every in-flight pair; no output afterwards until new input.
//  Pipeline: 3 register stages, latency exactly 3 accepted cycles from input handshake to m_axis_result_tvalid.
//   S1 unpack/classify, exponent sum, (MAN_W+1)x(MAN_W+1) mantissa product.
//   S2 normalise (product MSB at bit 2*MAN_W+1 or 2*MAN_W), RNE round, exponent adjust.
//   S3 special-case select, pack, flags -> output register.
//  Handshake: advance = aclken & (~S3_valid | m_axis_result_tready); s_axis_tready = advance.
//   Whole pipe advances together; bubbles move only on advance. Transfer on tvalid&tready both sides.
//   tdata/tuser stable while tvalid & ~tready. Full throughput 1 pair/cycle when tready held high.
//  Arithmetic: sign = sa^sb. Exponent sum ea+eb-bias in signed EXP_W+2 bits.
//   RNE on guard/sticky; tie rounds to even LSB; rounding carry-out renormalises (exp+1, mantissa 0).
//  Special cases (priority order):
//   any NaN input -> canonical qNaN {0, all-ones, 1'b1,0..} flags 000;
//   0 x Inf -> canonical qNaN, invalid_op=1;
//   Inf x finite -> signed Inf, flags 000;
//   zero or subnormal input -> signed zero (FTZ/DAZ), flags 000;
//   final biased exp >= all-ones -> signed Inf, overflow=1;
//   final biased exp <= 0 -> signed zero, underflow=1 (no subnormal outputs).
//  Simultaneous input accept and output drain in same cycle: both occur, no loss, order preserved.
//  aclken low with m_axis_result_tvalid high: output held unchanged.
// STRUCTURE
//  Package fp_pkg: function fp_bias(EXP_W), TUSER_UNF=0/TUSER_OVF=1/TUSER_INV=2, fp_class_t enum
//   {ZERO, NORM, INF, NAN}, canonical-qNaN builder function.
//  One sub-module: fp_norm_round (S2 combinational normalise + RNE, parametrised EXP_W/MAN_W).
//  Top owns handshake, stage registers, classify and pack.
// TESTING (binary32 defaults, tready=1 unless stated)
//  1. 0x40000000 x 0x40400000 -> 0x40C00000 (6.0), tuser 000, tvalid exactly 3 cycles later.
//  2. RNE: 0x3F800001 x 0x3F800001 -> 0x3F800002; 0x3FC00000 x 0x3FC00000 -> 0x40100000.
//  3. 0x7F7FFFFF x 0x40000000 -> 0x7F800000 tuser 010; 0x00000000 x 0x7F800000 -> 0x7FC00000 tuser 100.
//  4. 0x0DA24260 x 0x0DA24260 (1e-30^2) -> 0x00000000 tuser 001; 0xBF800000 x 0x00000001 -> 0x80000000 tuser 000.
//  5. Backpressure: 8 back-to-back pairs, tready low for 5 cycles mid-stream -> all 8 products, in order,
//   tdata stable while stalled, s_axis_tready low during stall.
//  6. aresetn pulsed low with 3 pairs in flight -> tvalid 0 immediately, none of those 3 emitted; next pair normal.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// operand classes, flag bit positions and constant builders.
package fp_pkg;

    localparam int TUSER_UNF = 0;
    localparam int TUSER_OVF = 1;
    localparam int TUSER_INV = 2;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Positive quiet NaN: exponent all ones, only the top fraction bit set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] q;
        q = '0;
        for (int i = 0; i < exp_w; i++) q[man_w + i] = 1'b1;
        q[man_w - 1] = 1'b1;
        return q;
    endfunction

    // Subnormals classify as ZERO: inputs are flushed (DAZ).
    function automatic fp_class_t fp_class(input logic exp_ones, input logic exp_zero,
                                           input logic man_zero);
        if (exp_ones) return man_zero ? INF : NAN;
        if (exp_zero) return ZERO;
        return NORM;
    endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Normalises the raw significand product and rounds it to nearest-even,
// adjusting the exponent for the normalising shift and any rounding carry.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [2*MAN_W+1:0] prod,
    input  logic [EXP_W+1:0]   exp_in,
    output logic [MAN_W-1:0]   man,
    output logic [EXP_W+1:0]   exp_out
);

    logic             msb;
    logic [MAN_W-1:0] frac;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [MAN_W:0]   man_r;

    always_comb begin
        msb      = prod[2*MAN_W+1];
        frac     = msb ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];
        guard    = msb ? prod[MAN_W] : prod[MAN_W-1];
        sticky   = msb ? (|prod[MAN_W-1:0]) : (|prod[MAN_W-2:0]);
        round_up = guard & (sticky | frac[0]);
        man_r    = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        // A carry out leaves the low bits all zero, which is already the 1.0 mantissa.
        man      = man_r[MAN_W-1:0];
        exp_out  = exp_in + {{(EXP_W+1){1'b0}}, msb} + {{(EXP_W+1){1'b0}}, man_r[MAN_W]};
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with AXI-Stream style
// valid/ready handshake, FTZ/DAZ and round-to-nearest-even.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         aclken,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic [W-1:0] s_axis_a_tdata,
    input  logic [W-1:0] s_axis_b_tdata,
    output logic         m_axis_result_tvalid,
    input  logic         m_axis_result_tready,
    output logic [W-1:0] m_axis_result_tdata,
    output logic [2:0]   m_axis_result_tuser
);

    localparam int               BIAS      = fp_bias(EXP_W);
    localparam logic [EXP_W+1:0] BIAS_X    = (EXP_W+2)'(BIAS);
    localparam logic [63:0]      QNAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];

    logic advance;

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    fp_class_t        ca, cb;
    logic [2*MAN_W+1:0] prod_c;
    logic [EXP_W+1:0]   esum_c;

    logic               v1, s1;
    fp_class_t          ca1, cb1;
    logic [EXP_W+1:0]   e1;
    logic [2*MAN_W+1:0] p1;

    logic [MAN_W-1:0] man_n;
    logic [EXP_W+1:0] exp_n;

    logic             v2, s2;
    fp_class_t        ca2, cb2;
    logic [EXP_W+1:0] e2;
    logic [MAN_W-1:0] m2;

    logic         v3;
    logic         ovf, unf;
    logic [W-1:0] res_c;
    logic [2:0]   flags_c;

    assign advance              = aclken & (~v3 | m_axis_result_tready);
    assign s_axis_tready        = advance & aresetn;
    assign m_axis_result_tvalid = v3;

    // S1: unpack, classify, exponent sum, significand product
    assign {sa, ea, ma} = s_axis_a_tdata;
    assign {sb, eb, mb} = s_axis_b_tdata;
    assign ca     = fp_class(&ea, ~|ea, ~|ma);
    assign cb     = fp_class(&eb, ~|eb, ~|mb);
    assign prod_c = {{(MAN_W+1){1'b0}}, 1'b1, ma} * {{(MAN_W+1){1'b0}}, 1'b1, mb};
    assign esum_c = {2'b00, ea} + {2'b00, eb} - BIAS_X;

    fp_norm_round #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_norm_round (
        .prod   (p1),
        .exp_in (e1),
        .man    (man_n),
        .exp_out(exp_n)
    );

    // S3: the exponent is signed, so overflow/underflow decode reads its sign bit.
    assign ovf = ~e2[EXP_W+1] & (e2[EXP_W] | (&e2[EXP_W-1:0]));
    assign unf = e2[EXP_W+1] | ~|e2;

    always_comb begin
        res_c   = {s2, e2[EXP_W-1:0], m2};
        flags_c = '0;
        if (ca2 == NAN || cb2 == NAN) begin
            res_c = QNAN;
        end else if ((ca2 == ZERO && cb2 == INF) || (ca2 == INF && cb2 == ZERO)) begin
            res_c              = QNAN;
            flags_c[TUSER_INV] = 1'b1;
        end else if (ca2 == INF || cb2 == INF) begin
            res_c = {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (ca2 == ZERO || cb2 == ZERO) begin
            res_c = {s2, {(W-1){1'b0}}};
        end else if (ovf) begin
            res_c              = {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c[TUSER_OVF] = 1'b1;
        end else if (unf) begin
            res_c              = {s2, {(W-1){1'b0}}};
            flags_c[TUSER_UNF] = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1                  <= 1'b0;
            s1                  <= 1'b0;
            ca1                 <= ZERO;
            cb1                 <= ZERO;
            e1                  <= '0;
            p1                  <= '0;
            v2                  <= 1'b0;
            s2                  <= 1'b0;
            ca2                 <= ZERO;
            cb2                 <= ZERO;
            e2                  <= '0;
            m2                  <= '0;
            v3                  <= 1'b0;
            m_axis_result_tdata <= '0;
            m_axis_result_tuser <= '0;
        end else if (advance) begin
            v1 <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                s1  <= sa ^ sb;
                ca1 <= ca;
                cb1 <= cb;
                e1  <= esum_c;
                p1  <= prod_c;
            end
            v2 <= v1;
            if (v1) begin
                s2  <= s1;
                ca2 <= ca1;
                cb2 <= cb1;
                e2  <= exp_n;
                m2  <= man_n;
            end
            v3 <= v2;
            if (v2) begin
                m_axis_result_tdata <= res_c;
                m_axis_result_tuser <= flags_c;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (binary32): directed corner products, backpressure,
// clock-enable freeze, mid-flight reset and randomized traffic against a real-arithmetic model.
module tb_fp_mul_pipe;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        aclken = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic [2:0]  m_user;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];
    bit rand_done = 1'b0;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .aclken              (aclken),
        .s_axis_tvalid       (s_valid),
        .s_axis_tready       (s_ready),
        .s_axis_a_tdata      (a),
        .s_axis_b_tdata      (b),
        .m_axis_result_tvalid(m_valid),
        .m_axis_result_tready(m_ready),
        .m_axis_result_tdata (m_data),
        .m_axis_result_tuser (m_user)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Exact product in double precision, then RNE down to single with FTZ.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
        int ex, ey, e;
        logic [22:0] mx, my, frac;
        logic s, g, st;
        bit nx, ny, ix, iy, zx, zy;
        real vx, vy, r;
        logic [63:0] bits;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        mx = x[22:0];        my = y[22:0];
        s  = x[31] ^ y[31];
        nx = (ex == 255) && (mx != 0); ny = (ey == 255) && (my != 0);
        ix = (ex == 255) && (mx == 0); iy = (ey == 255) && (my == 0);
        zx = (ex == 0);                zy = (ey == 0);
        if (nx || ny) return {3'b000, 32'h7FC00000};
        if ((ix && zy) || (zx && iy)) return {3'b100, 32'h7FC00000};
        if (ix || iy) return {3'b000, s, 8'hFF, 23'h0};
        if (zx || zy) return {3'b000, s, 31'h0};
        vx   = $bitstoreal({1'b0, 11'(ex - 127 + 1023), mx, 29'h0});
        vy   = $bitstoreal({1'b0, 11'(ey - 127 + 1023), my, 29'h0});
        r    = vx * vy;
        bits = $realtobits(r);
        e    = int'(bits[62:52]) - 1023 + 127;
        frac = bits[51:29];
        g    = bits[28];
        st   = |bits[27:0];
        if (g && (st || frac[0])) begin
            if (frac == '1) begin
                frac = '0;
                e++;
            end else begin
                frac = frac + 23'd1;
            end
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
        if (e <= 0) return {3'b001, s, 31'h0};
        return {3'b000, s, 8'(e), frac};
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        logic [31:0] v;
        k = $urandom_range(0, 19);
        v = $urandom;
        if (k == 0) v[30:23] = 8'h00;
        else if (k == 1) v[30:0] = {8'hFF, 23'h0};
        else if (k == 2) begin
            v[30:23] = 8'hFF;
            v[22]    = 1'b1;
        end else if (k < 14) v[30:23] = 8'($urandom_range(70, 185));
        else if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) v[30:23] = 8'h80;
        return v;
    endfunction

    // Output monitor: scoreboard pop on transfer, hold stability, tready forced low.
    logic        held_v = 1'b0;
    logic [34:0] held = '0;
    always @(negedge aclk) begin
        if (!aresetn) begin
            held_v = 1'b0;
        end else begin
            if (held_v) chk("hold_stable", {m_valid, m_user, m_data}, {1'b1, held});
            if (!aclken || (m_valid && !m_ready)) chk("s_ready_low", s_ready, 0);
            if (m_valid && m_ready && aclken) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_out: observed %h expected no output", m_data);
                end
                if (exp_q.size() != 0) chk("product", {m_user, m_data}, exp_q.pop_front());
            end
            held_v = m_valid && !(m_ready && aclken);
            held   = {m_user, m_data};
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [34:0] e);
        bit done;
        done    = 1'b0;
        s_valid = 1'b1;
        a       = x;
        b       = y;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge aclk);
            if (s_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge aclk);
            #1;
        end
        s_valid = 1'b0;
        chk("send_accept", done, 1);
    endtask

    task automatic sendm(input logic [31:0] x, input logic [31:0] y);
        send(x, y, model(x, y));
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge aclk);
        chk("drain", exp_q.size(), 0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_tvalid", m_valid, 0);
        chk("rst_tdata", m_data, 0);
        chk("rst_tuser", m_user, 0);
        chk("rst_tready", s_ready, 0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Latency: handshake cycle, then tvalid exactly three cycles later.
        s_valid = 1'b1;
        a = 32'h40000000;
        b = 32'h40400000;
        @(negedge aclk);
        chk("lat_accept", s_ready, 1);
        exp_q.push_back({3'b000, 32'h40C00000});
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        @(negedge aclk); chk("lat_c1", m_valid, 0);
        @(negedge aclk); chk("lat_c2", m_valid, 0);
        @(negedge aclk); chk("lat_c3", m_valid, 1);
        wait_drain();

        // Directed corner products.
        send(32'h3F800001, 32'h3F800001, {3'b000, 32'h3F800002});
        send(32'h3FC00000, 32'h3FC00000, {3'b000, 32'h40100000});
        send(32'h7F7FFFFF, 32'h40000000, {3'b010, 32'h7F800000});
        send(32'h00000000, 32'h7F800000, {3'b100, 32'h7FC00000});
        send(32'h0DA24260, 32'h0DA24260, {3'b001, 32'h00000000});
        send(32'hBF800000, 32'h00000001, {3'b000, 32'h80000000});
        send(32'hC0000000, 32'h40400000, {3'b000, 32'hC0C00000});
        send(32'hFF800001, 32'h3F800000, {3'b000, 32'h7FC00000});
        send(32'hFF800000, 32'h40000000, {3'b000, 32'hFF800000});
        send(32'h7F800000, 32'h80400000, {3'b100, 32'h7FC00000});
        wait_drain();

        // Backpressure: eight back-to-back pairs with a five-cycle stall.
        fork
            begin
                repeat (3) @(posedge aclk);
                #1 m_ready = 1'b0;
                repeat (5) @(posedge aclk);
                #1 m_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) sendm(rand_op(), rand_op());
        wait_drain();

        // Clock enable low freezes a pending output.
        m_ready = 1'b0;
        sendm(32'h40A00000, 32'h3E800000);
        for (int t = 0; t < 20 && !m_valid; t++) @(posedge aclk);
        #1;
        aclken  = 1'b0;
        m_ready = 1'b1;
        repeat (4) begin
            @(negedge aclk);
            chk("clken_valid_held", m_valid, 1);
        end
        @(posedge aclk);
        #1 aclken = 1'b1;
        wait_drain();

        // Reset with three pairs in flight discards them all.
        send(32'h40000000, 32'h40000000, {3'b000, 32'h40800000});
        send(32'h40400000, 32'h40400000, {3'b000, 32'h41100000});
        send(32'h40800000, 32'h40800000, {3'b000, 32'h41800000});
        aresetn = 1'b0;
        #1;
        chk("midrst_tvalid", m_valid, 0);
        chk("midrst_tready", s_ready, 0);
        chk("midrst_tdata", m_data, 0);
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (6) begin
            @(negedge aclk);
            chk("post_rst_idle", m_valid, 0);
        end
        @(posedge aclk);
        #1;
        send(32'h40000000, 32'h40400000, {3'b000, 32'h40C00000});
        wait_drain();

        // Randomized traffic with random downstream stalls and input gaps.
        fork
            begin
                while (!rand_done) begin
                    @(posedge aclk);
                    #1 m_ready = ($urandom_range(0, 3) != 0);
                end
                m_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge aclk);
                #1;
            end
            sendm(rand_op(), rand_op());
        end
        rand_done = 1'b1;
        @(posedge aclk);
        #2;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
